transmitter: RTL and testbench
==============================

# transmitter

Serial transmit engine of the UART16550 core and the counterpart of `receiver`. It accepts a parallel character plus a one-cycle strobe and serialises it onto `tx` LSB first. Each frame is start bit, 5–8 data bits, optional even parity and a stop bit, at a baud period of `baud_rate_cnt` system clocks. It sits between the transmit holding register/FIFO and the pad, and shares `word_length`, `baud_rate_cnt` and `parity_en` with `receiver`.

## Interface
- No parameters; all frame format is run-time configurable.
- `clk` in 1: system clock (50 MHz nominal).
- `rst_n` in 1: reset, asynchronous, active-low.
- `word_length` in 2: data bits = 5 + `word_length` (0→5, 1→6, 2→7, 3→8).
- `baud_rate_cnt` in 16: clocks per bit; for example 5208 gives 9600 Bd and 434 gives 115200 Bd at 50 MHz.
- `parity_en` in 1: 1 inserts an even-parity bit after the data bits.
- `pi_tx_data` in 8: character; bits above 4+`word_length` are ignored.
- `pi_flag` in 1: one-cycle start strobe; honoured only while idle.
- `tx` out 1: serial line; idles high.
- `po_busy` out 1: high from acceptance until the last stop-bit clock.
- `po_done` out 1: one-cycle pulse when the frame completes.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx`=1.
  - On `pi_flag`=1, latch `pi_tx_data`, `word_length`, `parity_en` and `baud_rate_cnt` into shadow registers, then go to START.
  - Format changes during a frame have no effect on that frame.
- **Baud counter:**
  - 16-bit, counts 0..N−1 with N = max(`baud_rate_cnt`,1).
  - The bit ends when count = N−1; the counter then clears.
  - A value of 0 is treated as 1 (one clock per bit).
- **START:** `tx`=0 for N clocks, then DATA with bit index 0.
- **DATA:**
  - `tx` = shadow data[index].
  - At each bit end, increment the 3-bit index.
  - After bit 4+wl, go to PARITY if parity is enabled, else STOP.
- **PARITY:** `tx` = XOR of the 5+wl transmitted data bits (even parity) for N clocks, then STOP.
- **STOP:**
  - `tx`=1 for N clocks (2N with the macro below).
  - At the end pulse `po_done` and return to IDLE.
- **Ignored strobes:** `pi_flag` while not IDLE is dropped; there is no queueing.
- **Reset (including mid-frame):**
  - Asynchronously forces IDLE, `tx`=1, `po_busy`=0, `po_done`=0.
  - Clears counters and shadow registers.
  - The partial frame is abandoned with no glitch low on `tx`.

## Timing
- **Reset values:** `tx`=1, `po_busy`=0, `po_done`=0. All outputs are registered.
- **Start of frame:** `pi_flag` sampled at edge k in IDLE → `tx`=0 and `po_busy`=1 from edge k onward (start bit occupies cycles k..k+N−1).
- **Frame length:** F = (7 + wl + parity_en)·N clocks; F + N with the macro.
- **End of frame:** `po_done`=1 and `po_busy`=0 for the cycle after the final stop clock, i.e. at edge k+F.
- **Back-to-back frames:** a `pi_flag` in the cycle `po_done` is high is accepted. The next start bit begins at edge k+F, giving zero idle gap between frames.
- **Bit-cell alignment:** bit j of the frame is driven on exactly clocks k+j·N .. k+(j+1)·N−1, with jitter 0.

## Configuration
- Macro `UART_TX_TWO_STOP_EN`.
- **Defined:** the STOP state lasts 2N clocks (two stop bits), matching 16550 LCR[2]=1 behaviour for 6–8 bit words. Frame length becomes F+N; `po_done` moves N clocks later.
- **Undefined:** exactly one stop bit of N clocks.
- No other behaviour changes.

## Structure
- **Shared package `uart_pkg`:**
  - state enum (IDLE/START/DATA/PARITY/STOP);
  - word-length encoding constants (WL_5..WL_8);
  - `DATA_W`=8 and `BAUD_W`=16.
  - It is shared with `receiver`.
- **Sub-module `uart_baud_cnt`:** the N-clock bit-period counter with clear and `bit_end` output. It is reusable by `receiver`, which uses a mid-bit tap.
- The parity XOR and the shift/index logic stay inline.

## Test plan
- **8N1, `baud_rate_cnt`=16, data 0xA5:** `tx` = 0,1,0,1,0,0,1,0,1,1, each held 16 clocks; `po_done` at k+160; `po_busy` high 160 cycles.
- **7E1, `baud_rate_cnt`=434, data 0xFC:**
  - data bits 0,0,1,1,1,1,1;
  - parity bit = 1 (five ones);
  - frame = 10·434 = 4340 clocks.
- **Loopback into `receiver`:** `tx` looped to `receiver.rx` for 5N1, 6E1 and 8E1 at 5208 with data 0x0F, 0x2A, 0x6A. `po_rx_data` must equal the sent data and `po_flag` must fire once per frame.
- **Strobe while busy:** a second `pi_flag` at k+50 (N=16, 8N1) is ignored. A strobe in the `po_done` cycle starts the next frame at k+160 with no idle gap.
- **Reset mid-frame:** deassert `rst_n` during data bit 3. `tx` goes to 1 asynchronously and `po_busy` goes to 0. After release, a new 0x55 frame is sent cleanly.
- **Edge cases:**
  - `baud_rate_cnt`=0 and 1: each bit lasts one clock, and an 8N1 frame takes 10 clocks.
  - With `UART_TX_TWO_STOP_EN`, an 8N1 frame at N=16 takes 176 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by transmitter and receiver: frame FSM states,
// word-length encodings, datapath widths and a data-bit mask helper.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int BAUD_W = 16;

  // word_length encodings: data bits = 5 + word_length
  localparam logic [1:0] WL_5 = 2'd0;
  localparam logic [1:0] WL_6 = 2'd1;
  localparam logic [1:0] WL_7 = 2'd2;
  localparam logic [1:0] WL_8 = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Mask selecting the data bits actually carried for a given word length.
  function automatic logic [DATA_W-1:0] wl_mask(input logic [1:0] wl);
    logic [DATA_W-1:0] m;
    case (wl)
      WL_5:    m = 8'h1F;
      WL_6:    m = 8'h3F;
      WL_7:    m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..N-1 with N = max(n_i,1) and flags the last
// clock of each bit cell. Held at zero while clr_i is high.
module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [BAUD_W-1:0] n_i,
  output logic              bit_end_o
);

  logic [BAUD_W-1:0] cnt_q;
  logic [BAUD_W-1:0] cnt_d;
  logic [BAUD_W-1:0] last_w;

  // A period of 0 behaves like 1, so the last count is simply n_i-1 clamped at 0.
  always_comb begin
    last_w    = (n_i == '0) ? '0 : n_i - 1'b1;
    bit_end_o = !clr_i && (cnt_q == last_w);
    cnt_d     = (clr_i || bit_end_o) ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/transmitter.sv
// UART serial transmit engine: start bit, 5..8 data bits LSB first, optional
// even parity, stop bit(s). Frame format is shadowed at acceptance so input
// changes mid-frame do not disturb the current frame.
// Optional macro UART_TX_TWO_STOP_EN: send two stop bits instead of one.
module transmitter
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        word_length,
  input  logic [BAUD_W-1:0] baud_rate_cnt,
  input  logic              parity_en,
  input  logic [DATA_W-1:0] pi_tx_data,
  input  logic              pi_flag,
  output logic              tx,
  output logic              po_busy,
  output logic              po_done
);

  uart_state_e       state_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        wl_q;
  logic              par_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
`ifdef UART_TX_TWO_STOP_EN
  logic              stop2_q;
`endif

  logic       bit_end_w;
  logic       frame_end_w;
  logic       accept_w;
  logic [2:0] idx_d;
  logic [2:0] last_idx_w;
  logic       parity_w;

  uart_baud_cnt u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == IDLE),
    .n_i       (baud_q),
    .bit_end_o (bit_end_w)
  );

  // Frame-end detection, strobe acceptance, index and parity helpers.
  // A strobe on the final stop clock is accepted so frames can run with no gap.
  always_comb begin
`ifdef UART_TX_TWO_STOP_EN
    frame_end_w = (state_q == STOP) && bit_end_w && stop2_q;
`else
    frame_end_w = (state_q == STOP) && bit_end_w;
`endif
    accept_w   = pi_flag && ((state_q == IDLE) || frame_end_w);
    idx_d      = idx_q + 3'd1;
    last_idx_w = 3'd4 + {1'b0, wl_q};
    parity_w   = ^(data_q & wl_mask(wl_q));
  end

  // Shadow copy of the character and frame format, taken at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      wl_q   <= '0;
      par_q  <= 1'b0;
      baud_q <= '0;
    end else if (accept_w) begin
      data_q <= pi_tx_data;
      wl_q   <= word_length;
      par_q  <= parity_en;
      baud_q <= baud_rate_cnt;
    end
  end

  // Frame FSM; tx/busy/done are registered and change on bit-cell boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (accept_w) begin
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end_w) begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= data_q[0];
          end
        end
        DATA: begin
          if (bit_end_w) begin
            if (idx_q == last_idx_w) begin
              state_q <= par_q ? PARITY : STOP;
              tx_q    <= par_q ? parity_w : 1'b1;
            end else begin
              idx_q <= idx_d;
              tx_q  <= data_q[idx_d];
            end
          end
        end
        PARITY: begin
          if (bit_end_w) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (bit_end_w && !stop2_q) stop2_q <= 1'b1;
`endif
          if (frame_end_w) begin
`ifdef UART_TX_TWO_STOP_EN
            stop2_q <= 1'b0;
`endif
            done_q <= 1'b1;
            idx_q  <= '0;
            if (accept_w) begin
              state_q <= START;
              tx_q    <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign po_busy = busy_q;
  assign po_done = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: directed and randomized frames checked cycle by
// cycle against a frame-level reference model (list of bit values, each held
// N clocks).
module tb_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  word_length = 2'd0;
  logic [15:0] baud_rate_cnt = 16'd0;
  logic        parity_en = 1'b0;
  logic [7:0]  pi_tx_data = 8'd0;
  logic        pi_flag = 1'b0;
  logic        tx;
  logic        po_busy;
  logic        po_done;

  int vectors = 0;
  int miscompares = 0;

  transmitter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .word_length   (word_length),
    .baud_rate_cnt (baud_rate_cnt),
    .parity_en     (parity_en),
    .pi_tx_data    (pi_tx_data),
    .pi_flag       (pi_flag),
    .tx            (tx),
    .po_busy       (po_busy),
    .po_done       (po_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, even parity, stop bit(s).
  function automatic int frame_bits(input logic [7:0] d, input logic [1:0] wl,
                                    input logic p, output logic [11:0] bits);
    int nb;
    int ones;
    int ndata;
    bits  = '1;
    ndata = 5 + int'(wl);
    ones  = 0;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < ndata; i++) begin
      bits[nb] = d[i];
      if (d[i]) ones++;
      nb++;
    end
    if (p) begin
      bits[nb] = (ones % 2 == 1);
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
`ifdef UART_TX_TWO_STOP_EN
    bits[nb] = 1'b1;
    nb++;
`endif
    return nb;
  endfunction

  // Present a strobe; returns at the negedge of the first start-bit cycle.
  task automatic start_frame(input logic [7:0] d, input logic [1:0] wl,
                             input logic p, input logic [15:0] b);
    pi_tx_data    = d;
    word_length   = wl;
    parity_en     = p;
    baud_rate_cnt = b;
    pi_flag       = 1'b1;
    @(negedge clk);
    pi_flag = 1'b0;
  endtask

  // Check a whole frame starting at the current negedge (first start cycle).
  // junk: cycle offset of an ignored strobe, -1 none, -2 random.
  // chain: strobe the next frame on the final stop clock.
  task automatic check_frame(input logic [7:0] d, input logic [1:0] wl,
                             input logic p, input logic [15:0] b, input int junk_in,
                             input bit chain, input logic [7:0] nd,
                             input logic [1:0] nwl, input logic np,
                             input logic [15:0] nbaud);
    logic [11:0] bits;
    int nbits, n, f, junk;
    nbits = frame_bits(d, wl, p, bits);
    n = (b == 16'd0) ? 1 : int'(b);
    f = nbits * n;
    junk = junk_in;
    if (junk == -2) junk = (f >= 3) ? int'($urandom_range(f - 2, 1)) : -1;
    for (int c = 0; c < f; c++) begin
      chk("tx_bit", tx, bits[c / n]);
      chk("busy_frame", po_busy, 1);
      if (c > 0) chk("done_mid", po_done, 0);
      if (chain && c == f - 1) begin
        pi_flag       = 1'b1;
        pi_tx_data    = nd;
        word_length   = nwl;
        parity_en     = np;
        baud_rate_cnt = nbaud;
      end else begin
        pi_flag       = (c == junk);
        pi_tx_data    = 8'($urandom);
        word_length   = 2'($urandom);
        parity_en     = 1'($urandom);
        baud_rate_cnt = 16'($urandom);
      end
      @(negedge clk);
    end
    pi_flag = 1'b0;
    chk("done_end", po_done, 1);
    chk("busy_end", po_busy, chain);
    if (!chain) begin
      chk("tx_end", tx, 1);
      @(negedge clk);
      chk("done_pulse", po_done, 0);
      chk("tx_idle", tx, 1);
      chk("busy_idle", po_busy, 0);
    end
  endtask

  initial begin
    logic [7:0]  cd, nd;
    logic [1:0]  cwl, nwl;
    logic        cp, np;
    logic [15:0] cb, nb;
    bit          ch;
    logic [11:0] rbits;
    int          rn;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", po_busy, 0);
    chk("rst_done", po_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 N=16 0xA5 with an ignored strobe at k+50
    start_frame(8'hA5, 2'd3, 1'b0, 16'd16);
    check_frame(8'hA5, 2'd3, 1'b0, 16'd16, 50, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0);

    // 7E1 N=434 0xFC
    start_frame(8'hFC, 2'd2, 1'b1, 16'd434);
    check_frame(8'hFC, 2'd2, 1'b1, 16'd434, -1, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0);

    // Back-to-back: 8N1 N=16 chained into 6E1 N=5
    start_frame(8'h3C, 2'd3, 1'b0, 16'd16);
    check_frame(8'h3C, 2'd3, 1'b0, 16'd16, -1, 1'b1, 8'h2A, 2'd1, 1'b1, 16'd5);
    check_frame(8'h2A, 2'd1, 1'b1, 16'd5, -1, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0);

    // One-clock bit cells with baud 0 and 1
    start_frame(8'h96, 2'd3, 1'b0, 16'd0);
    check_frame(8'h96, 2'd3, 1'b0, 16'd0, -1, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0);
    start_frame(8'h69, 2'd3, 1'b0, 16'd1);
    check_frame(8'h69, 2'd3, 1'b0, 16'd1, -1, 1'b1, 8'h0F, 2'd0, 1'b0, 16'd1);
    check_frame(8'h0F, 2'd0, 1'b0, 16'd1, -1, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0);

    // Randomized frames, some chained, with stray strobes while busy
    cd  = 8'($urandom);
    cwl = 2'($urandom);
    cp  = 1'($urandom);
    cb  = ($urandom_range(9, 0) == 0) ? 16'd0 : 16'($urandom_range(24, 1));
    start_frame(cd, cwl, cp, cb);
    for (int i = 0; i < 24; i++) begin
      nd  = 8'($urandom);
      nwl = 2'($urandom);
      np  = 1'($urandom);
      nb  = ($urandom_range(9, 0) == 0) ? 16'd0 : 16'($urandom_range(24, 1));
      ch  = (i < 23) ? bit'($urandom_range(1, 0)) : 1'b0;
      check_frame(cd, cwl, cp, cb, ($urandom_range(1, 0) == 1) ? -2 : -1, ch, nd, nwl, np, nb);
      if (!ch && i < 23) start_frame(nd, nwl, np, nb);
      cd = nd; cwl = nwl; cp = np; cb = nb;
    end

    // Reset mid-frame during data bit 3 of an 8N1 0x55 frame, then resend
    repeat (2) @(negedge clk);
    start_frame(8'h55, 2'd3, 1'b0, 16'd16);
    rn = frame_bits(8'h55, 2'd3, 1'b0, rbits);
    for (int c = 0; c < 70; c++) begin
      chk("pre_rst_tx", tx, rbits[c / 16]);
      @(negedge clk);
    end
    chk("pre_rst_low", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", po_busy, 0);
    chk("async_rst_done", po_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_tx", tx, 1);
      chk("post_rst_busy", po_busy, 0);
    end
    start_frame(8'h55, 2'd3, 1'b0, 16'd16);
    check_frame(8'h55, 2'd3, 1'b0, 16'd16, -1, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
